iiitb_tlc: RTL and testbench



---
 rtl/iiitb_tlc.sv | 98 +++++++++
 tb/tb_iiitb_tlc.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/iiitb_tlc.sv
// iiitb_tlc - highway / farm-road crossing traffic light controller.
// Highway shows green by default. A farm-road vehicle request sensed while
// highway is green runs the timed sequence highway yellow -> farm green ->
// farm yellow -> highway green. Timing is counted in ticks of TICK_DIV clocks.
//
// Ports:
//   light_highway [2:0] out  highway lamps, one-hot {red, yellow, green}
//   light_farm    [2:0] out  farm-road lamps, same encoding
//   sensor              in   farm-road vehicle present (synchronous to clk)
//   clk                 in   system clock, rising edge
//   rst_n               in   synchronous active-low reset
module iiitb_tlc #(
  parameter int unsigned TICK_DIV         = 4,
  parameter int unsigned YELLOW_TICKS     = 3,
  parameter int unsigned FARM_GREEN_TICKS = 10
) (
  output logic [2:0] light_highway,
  output logic [2:0] light_farm,
  input  logic       sensor,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DMAX =
    ((YELLOW_TICKS > FARM_GREEN_TICKS) ? YELLOW_TICKS : FARM_GREEN_TICKS) - 1;
  localparam int unsigned DW = (DMAX > 0) ? $clog2(DMAX + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] YELLOW_LAST = DW'(YELLOW_TICKS - 1);
  localparam logic [DW-1:0] FGREEN_LAST = DW'(FARM_GREEN_TICKS - 1);

  typedef enum logic [1:0] {
    HGRE_FRED = 2'b00,
    HYEL_FRED = 2'b01,
    HRED_FGRE = 2'b10,
    HRED_FYEL = 2'b11
  } state_t;

  state_t          state, next_state;
  logic [TW-1:0]   tick_cnt;
  logic [DW-1:0]   dwell_cnt;
  logic            tick;
  logic            state_change;

  assign tick         = (tick_cnt == TICK_LAST);
  assign state_change = (next_state != state);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HGRE_FRED;
    end else begin
      state <= next_state;
    end
  end

  // Counters restart on every state change so each timed state lasts exactly
  // N*TICK_DIV cycles; they stay idle while highway is green.
  always_ff @(posedge clk) begin
    if (!rst_n || state_change || state == HGRE_FRED) begin
      tick_cnt  <= '0;
      dwell_cnt <= '0;
    end else if (tick) begin
      tick_cnt  <= '0;
      dwell_cnt <= dwell_cnt + 1'b1;
    end else begin
      tick_cnt  <= tick_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      HGRE_FRED: if (sensor)                            next_state = HYEL_FRED;
      HYEL_FRED: if (tick && dwell_cnt == YELLOW_LAST)  next_state = HRED_FGRE;
      HRED_FGRE: if (tick && dwell_cnt == FGREEN_LAST)  next_state = HRED_FYEL;
      HRED_FYEL: if (tick && dwell_cnt == YELLOW_LAST)  next_state = HGRE_FRED;
      default:                                          next_state = HGRE_FRED;
    endcase
  end

  always_comb begin
    light_highway = GREEN;
    light_farm    = RED;
    case (state)
      HGRE_FRED: begin light_highway = GREEN;  light_farm = RED;    end
      HYEL_FRED: begin light_highway = YELLOW; light_farm = RED;    end
      HRED_FGRE: begin light_highway = RED;    light_farm = GREEN;  end
      HRED_FYEL: begin light_highway = RED;    light_farm = YELLOW; end
      default:   begin light_highway = GREEN;  light_farm = RED;    end
    endcase
  end

endmodule

// File: tb/tb_iiitb_tlc.sv
// Directed bench for iiitb_tlc with default parameters (4 / 3 / 10):
// yellow = 12 cycles, farm green = 40 cycles, full sequence = 64 cycles.
module tb_iiitb_tlc;

  logic       clk;
  logic       rst_n;
  logic       sensor;
  logic [2:0] light_highway;
  logic [2:0] light_farm;

  int unsigned vectors;
  int unsigned miscompares;

  iiitb_tlc #(
    .TICK_DIV         (4),
    .YELLOW_TICKS     (3),
    .FARM_GREEN_TICKS (10)
  ) dut (
    .light_highway (light_highway),
    .light_farm    (light_farm),
    .sensor        (sensor),
    .clk           (clk),
    .rst_n         (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected lamps p cycles after the request edge (p=0 is the request edge).
  function automatic logic [2:0] exp_hw(int p);
    if (p < 12)      return 3'b010;
    else if (p < 64) return 3'b100;
    else             return 3'b001;
  endfunction

  function automatic logic [2:0] exp_fm(int p);
    if (p < 12)      return 3'b100;
    else if (p < 52) return 3'b001;
    else if (p < 64) return 3'b010;
    else             return 3'b100;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    sensor = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (light_highway !== 3'b001 || light_farm !== 3'b100) begin
        miscompares++;
        $display("FAIL reset[%0d]: got hw=%b farm=%b, want hw=001 farm=100",
                 i, light_highway, light_farm);
      end
    end
    sensor = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic test_idle();
    sensor = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      vectors++;
      if (light_highway !== 3'b001 || light_farm !== 3'b100) begin
        miscompares++;
        $display("FAIL idle[%0d]: got hw=%b farm=%b, want hw=001 farm=100",
                 i, light_highway, light_farm);
      end
    end
  endtask

  task automatic test_single();
    sensor = 1'b1;
    step();
    sensor = 1'b0;
    for (int p = 0; p < 100; p++) begin
      vectors++;
      if (light_highway !== exp_hw(p) || light_farm !== exp_fm(p)) begin
        miscompares++;
        $display("FAIL single[%0d]: got hw=%b farm=%b, want hw=%b farm=%b",
                 p, light_highway, light_farm, exp_hw(p), exp_fm(p));
      end
      step();
    end
  endtask

  task automatic test_sustained();
    sensor = 1'b1;
    step();
    for (int i = 0; i < 600; i++) begin
      vectors++;
      if (light_highway !== exp_hw(i % 65) || light_farm !== exp_fm(i % 65)) begin
        miscompares++;
        $display("FAIL sustained[%0d]: got hw=%b farm=%b, want hw=%b farm=%b",
                 i, light_highway, light_farm, exp_hw(i % 65), exp_fm(i % 65));
      end
      step();
    end
    sensor = 1'b0;
    repeat (70) step();
    vectors++;
    if (light_highway !== 3'b001 || light_farm !== 3'b100) begin
      miscompares++;
      $display("FAIL sustained_end: got hw=%b farm=%b, want hw=001 farm=100",
               light_highway, light_farm);
    end
  endtask

  task automatic test_sensor_ignored();
    sensor = 1'b1;
    step();
    for (int p = 0; p < 100; p++) begin
      // Toggle through all timed states; must be low once highway is green again.
      sensor = (p < 64) ? p[0] : 1'b0;
      vectors++;
      if (light_highway !== exp_hw(p) || light_farm !== exp_fm(p)) begin
        miscompares++;
        $display("FAIL ignored[%0d]: got hw=%b farm=%b, want hw=%b farm=%b",
                 p, light_highway, light_farm, exp_hw(p), exp_fm(p));
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    sensor = 1'b1;
    step();
    sensor = 1'b0;
    repeat (20) step();
    vectors++;
    if (light_highway !== 3'b100 || light_farm !== 3'b001) begin
      miscompares++;
      $display("FAIL midrst_pre: got hw=%b farm=%b, want hw=100 farm=001",
               light_highway, light_farm);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (light_highway !== 3'b001 || light_farm !== 3'b100) begin
        miscompares++;
        $display("FAIL midrst_post[%0d]: got hw=%b farm=%b, want hw=001 farm=100",
                 i, light_highway, light_farm);
      end
      step();
    end
    sensor = 1'b1;
    step();
    sensor = 1'b0;
    for (int p = 0; p < 70; p++) begin
      vectors++;
      if (light_highway !== exp_hw(p) || light_farm !== exp_fm(p)) begin
        miscompares++;
        $display("FAIL midrst_seq[%0d]: got hw=%b farm=%b, want hw=%b farm=%b",
                 p, light_highway, light_farm, exp_hw(p), exp_fm(p));
      end
      step();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    sensor      = 1'b0;
    test_reset();
    test_idle();
    test_single();
    test_sustained();
    test_sensor_ignored();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
